// File: rtl/instr_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage: instruction field
// positions, the decode FSM state type and the decoded-control bundle.
package instr_decode_stage_pkg;

  localparam int unsigned ALU_HI      = 31;
  localparam int unsigned ALU_LO      = 29;
  localparam int unsigned REG1_WR_BIT = 28;
  localparam int unsigned REG2_WR_BIT = 27;
  localparam int unsigned RAM_WR_BIT  = 26;
  localparam int unsigned MUX_L_HI    = 25;
  localparam int unsigned MUX_L_LO    = 24;
  localparam int unsigned MUX_R_HI    = 23;
  localparam int unsigned MUX_R_LO    = 22;
  localparam int unsigned RAM_RD_BIT  = 21;
  localparam int unsigned EXT_BIT     = 20;
  localparam int unsigned RSV_HI      = 19;
  localparam int unsigned RSV_LO      = 16;
  localparam int unsigned IMM_HI      = 15;
  localparam int unsigned IMM_LO      = 0;

  typedef enum logic {
    IDLE     = 1'b0,
    EXT_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg1_wr;
    logic       reg2_wr;
    logic       ram_wr;
    logic       ram_rd;
    logic [1:0] mux_l;
    logic [1:0] mux_r;
  } ctrl_t;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master: the fetch/execute environment; slave: the decode stage itself.
interface instr_decode_stage_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CNT_W   = 16
);
  logic               IN_VALID;
  logic               IN_READY;
  logic [INSTR_W-1:0] INSTRUCTION;
  logic               FLUSH;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [2:0]         ALU_OPERATION;
  logic               REG1_WR;
  logic               REG2_WR;
  logic               RAM_WR;
  logic               RAM_RD;
  logic [1:0]         MUX_ALU_IN_LEFT;
  logic [1:0]         MUX_ALU_IN_RIGHT;
  logic [DATA_W-1:0]  DATA;
  logic               ILLEGAL;
  logic [CNT_W-1:0]   DECODE_COUNT;

  modport master (
    output IN_VALID, INSTRUCTION, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, ALU_OPERATION, REG1_WR, REG2_WR, RAM_WR,
           RAM_RD, MUX_ALU_IN_LEFT, MUX_ALU_IN_RIGHT, DATA, ILLEGAL,
           DECODE_COUNT
  );

  modport slave (
    input  IN_VALID, INSTRUCTION, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, ALU_OPERATION, REG1_WR, REG2_WR, RAM_WR,
           RAM_RD, MUX_ALU_IN_LEFT, MUX_ALU_IN_RIGHT, DATA, ILLEGAL,
           DECODE_COUNT
  );
endinterface

// File: rtl/instr_decode_stage_field_extract.sv
// instr_field_extract: combinational split of a 32-bit instruction word into
// decoded controls, immediate and extension flag, plus the illegal check.
// Optional macro DECODER_ILLEGAL_TRAP_EN enables illegal-encoding trapping.
module instr_field_extract
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [31:0] word,
  output ctrl_t       ctrl,
  output logic [15:0] imm,
  output logic        ext,
  output logic        illegal
);

  // Field split, then illegal trapping squashes side effects and suppresses EXT
  always_comb begin
    ctrl.alu_op  = word[ALU_HI:ALU_LO];
    ctrl.reg1_wr = word[REG1_WR_BIT];
    ctrl.reg2_wr = word[REG2_WR_BIT];
    ctrl.ram_wr  = word[RAM_WR_BIT];
    ctrl.ram_rd  = word[RAM_RD_BIT];
    ctrl.mux_l   = word[MUX_L_HI:MUX_L_LO];
    ctrl.mux_r   = word[MUX_R_HI:MUX_R_LO];
    imm          = word[IMM_HI:IMM_LO];
`ifdef DECODER_ILLEGAL_TRAP_EN
    illegal = (word[RAM_WR_BIT] && word[RAM_RD_BIT])
           || (word[RSV_HI:RSV_LO] != '0)
           || (word[EXT_BIT] && (DATA_W == 16));
    if (illegal) begin
      ctrl.reg1_wr = 1'b0;
      ctrl.reg2_wr = 1'b0;
      ctrl.ram_wr  = 1'b0;
      ctrl.ram_rd  = 1'b0;
    end
    ext = word[EXT_BIT] && (DATA_W == 32) && !illegal;
`else
    illegal = 1'b0;
    ext     = word[EXT_BIT] && (DATA_W == 32);
`endif
  end

  // Reserved bits only matter to the illegal check
  logic unused_rsv;
  assign unused_rsv = ^word[RSV_HI:RSV_LO];

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered, valid/ready decode stage between FLASH fetch
// and execute. Supports two-word extended immediates (DATA_W=32), flush and a
// retired-decode counter. Optional macro DECODER_ILLEGAL_TRAP_EN enables
// illegal-encoding trapping in instr_field_extract.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  instr_decode_stage_if.slave  bus
);

  ctrl_t             ex_ctrl;
  logic [15:0]       ex_imm;
  logic              ex_ext;
  logic              ex_illegal;

  state_e            state_q, state_d;
  ctrl_t             out_ctrl_q, out_ctrl_d;
  ctrl_t             hold_ctrl_q, hold_ctrl_d;
  logic [15:0]       hold_imm_q, hold_imm_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              illegal_q, illegal_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              in_ready;
  logic              accept;
  logic              out_hs;

  instr_field_extract #(
    .DATA_W (DATA_W)
  ) u_extract (
    .word    (bus.INSTRUCTION[31:0]),
    .ctrl    (ex_ctrl),
    .imm     (ex_imm),
    .ext     (ex_ext),
    .illegal (ex_illegal)
  );

  // Input handshake qualifiers
  always_comb begin
    in_ready = RST_N && !bus.FLUSH && (!out_valid_q || bus.OUT_READY);
    accept   = bus.IN_VALID && in_ready;
    out_hs   = out_valid_q && bus.OUT_READY;
  end

  // Next-state: flush dominates; drain and reload may share one cycle
  always_comb begin
    state_d     = state_q;
    out_ctrl_d  = out_ctrl_q;
    hold_ctrl_d = hold_ctrl_q;
    hold_imm_d  = hold_imm_q;
    data_d      = data_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;
    if (bus.FLUSH) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else begin
      if (out_hs) begin
        out_valid_d = 1'b0;
        count_d     = count_q + CNT_W'(1);
      end
      if (accept) begin
        if (state_q == EXT_WAIT) begin
          out_ctrl_d  = hold_ctrl_q;
          data_d      = DATA_W'({bus.INSTRUCTION[15:0], hold_imm_q});
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (ex_ext) begin
          hold_ctrl_d = ex_ctrl;
          hold_imm_d  = ex_imm;
          state_d     = EXT_WAIT;
        end else begin
          out_ctrl_d  = ex_ctrl;
          data_d      = DATA_W'(ex_imm);
          illegal_d   = ex_illegal;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  // Stage register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      out_ctrl_q  <= '0;
      hold_ctrl_q <= '0;
      hold_imm_q  <= '0;
      data_q      <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_ctrl_q  <= out_ctrl_d;
      hold_ctrl_q <= hold_ctrl_d;
      hold_imm_q  <= hold_imm_d;
      data_q      <= data_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign bus.IN_READY         = in_ready;
  assign bus.OUT_VALID        = out_valid_q;
  assign bus.ALU_OPERATION    = out_ctrl_q.alu_op;
  assign bus.REG1_WR          = out_ctrl_q.reg1_wr;
  assign bus.REG2_WR          = out_ctrl_q.reg2_wr;
  assign bus.RAM_WR           = out_ctrl_q.ram_wr;
  assign bus.RAM_RD           = out_ctrl_q.ram_rd;
  assign bus.MUX_ALU_IN_LEFT  = out_ctrl_q.mux_l;
  assign bus.MUX_ALU_IN_RIGHT = out_ctrl_q.mux_r;
  assign bus.DATA             = data_q;
  assign bus.ILLEGAL          = illegal_q;
  assign bus.DECODE_COUNT     = count_q;

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, handshaked successor to the combinational instruction decoder. Accepts instruction words from the FLASH fetch path over a valid/ready interface, decodes them into ALU, register-file, RAM and ALU-mux control, and presents the result as one pipeline register to the execute stage. It adds parametrised immediate width, two-word extended immediates, a driven RAM read enable, flush, and a retired-decode counter.

## Interface
- INSTR_W, 32: instruction word width; must be at least 32, and bits above 31 are ignored.
- DATA_W, 16: immediate width; legal values are 16 or 32. With 32, extended immediates are enabled.
- CNT_W, 16: width of DECODE_COUNT.
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  synchronous reset, active low.
- IN_VALID  in  1  the fetch word on INSTRUCTION is valid.
- IN_READY  out  1  the decoder accepts INSTRUCTION this cycle.
- INSTRUCTION  in  INSTR_W  instruction word from FLASH.
- FLUSH  in  1  synchronous discard of all in-flight state (branch or redirect).
- OUT_VALID  out  1  the decoded control set is valid.
- OUT_READY  in  1  the execute stage takes the decoded set.
- ALU_OPERATION  out  3  ALU function.
- REG1_WR, REG2_WR  out  1 each  register write enables.
- RAM_WR, RAM_RD  out  1 each  RAM write and read enables.
- MUX_ALU_IN_LEFT, MUX_ALU_IN_RIGHT  out  2 each  ALU operand selects.
- DATA  out  DATA_W  immediate value.
- ILLEGAL  out  1  the decoded word is an illegal encoding; qualified by OUT_VALID.
- DECODE_COUNT  out  CNT_W  count of output handshakes.

## Operation
- Field map:
  - [31:29] ALU_OPERATION
  - [28] REG1_WR
  - [27] REG2_WR
  - [26] RAM_WR
  - [25:24] MUX_ALU_IN_LEFT
  - [23:22] MUX_ALU_IN_RIGHT
  - [21] RAM_RD
  - [20] EXT
  - [19:16] reserved
  - [15:0] IMM
- Input acceptance: a word is accepted when IN_VALID && IN_READY. IN_READY = RST_N && !FLUSH && (!OUT_VALID || OUT_READY).
- State machine with two states, IDLE and EXT_WAIT:
  - IDLE, accepted word with EXT=0 or DATA_W=16: load the output register, set OUT_VALID=1, stay in IDLE.
  - IDLE, accepted word with EXT=1 and DATA_W=32: latch the fields and IMM into hold registers and go to EXT_WAIT. The output register is not loaded.
  - EXT_WAIT, accepted word: load the output from the held fields, with DATA = {word[15:0], held IMM}. Set OUT_VALID=1 and return to IDLE. The extension word's bits [31:16] are don't-care.
- Immediate width: with DATA_W=32 and a single-word instruction, DATA = zero-extended IMM.
- OUT_VALID clears on an output handshake unless a new word loads in the same cycle. If an opcode word is accepted in IDLE with EXT=1 while the old output drains, OUT_VALID goes to 0.
- Stalls: while OUT_VALID && !OUT_READY, every output holds stable.
- DECODE_COUNT increments by 1 on each OUT_VALID && OUT_READY and wraps modulo 2^CNT_W. An extended instruction counts once.
- FLUSH:
  - Clears OUT_VALID and returns to IDLE; hold registers are discarded.
  - DECODE_COUNT is unchanged.
  - FLUSH takes priority over a simultaneous output handshake: the count does not increment.
- Reset: RST_N=0 takes priority over FLUSH and handshakes, including in EXT_WAIT.

## Timing
- Latency: 1 cycle from acceptance of the final word to OUT_VALID. An extended instruction takes at least 2 input cycles.
- Throughput: one single-word instruction per cycle when OUT_READY=1.
- IN_READY is combinational from OUT_VALID, OUT_READY, FLUSH and RST_N. All other outputs are registered.
- Reset values:
  - OUT_VALID=0, IN_READY=0 while RST_N=0.
  - All control outputs 0, DATA=0, ILLEGAL=0, DECODE_COUNT=0.
  - State IDLE.

## Configuration
- DECODER_ILLEGAL_TRAP_EN defined: a word is illegal when any of these holds:
  - RAM_WR && RAM_RD
  - reserved bits [19:16] are nonzero
  - EXT=1 with DATA_W=16
  
  For an illegal word:
  - ILLEGAL=1.
  - REG1_WR, REG2_WR, RAM_WR and RAM_RD are forced to 0.
  - The word is always treated as single-word, with no EXT_WAIT entry.
  - The word is still passed downstream and counted.
- Undefined: no checks. ILLEGAL is tied to 0, and EXT with DATA_W=16 is ignored.

## Structure
- Shared package holds:
  - field bit-position constants
  - the state enum (IDLE, EXT_WAIT)
  - a decoded-control struct (alu_op, reg1_wr, reg2_wr, ram_wr, ram_rd, mux_l, mux_r)
- One sub-module, instr_field_extract: combinational word-to-struct extraction plus the illegal check. It is reused by the future disassembler and monitor.
- The stage register, FSM and counter stay in instr_decode_stage.

## Test plan
- Single-word decode: 0x5E40_1234 is accepted with OUT_READY=1. Next cycle: OUT_VALID=1, ALU_OPERATION=2, REG1_WR=1, REG2_WR=1, RAM_WR=1, MUX_ALU_IN_LEFT=2, MUX_ALU_IN_RIGHT=1, RAM_RD=0, DATA=0x1234, DECODE_COUNT=1.
- Extended immediate (DATA_W=32): 0x2010_BEEF, then 0x0000_DEAD. OUT_VALID=0 after the first word; after the second, DATA=0xDEAD_BEEF and ALU_OPERATION=1. DECODE_COUNT increments once.
- Backpressure: OUT_READY=0 for 3 cycles with IN_VALID=1 streaming. IN_READY=0 and the outputs hold; on release, back-to-back words flow one per cycle.
- Flush in EXT_WAIT: FLUSH after an EXT opcode word. The state is IDLE and a following single-word instruction decodes normally; the stale immediate never appears.
- Illegal trap (DECODER_ILLEGAL_TRAP_EN): RAM_WR and RAM_RD both set, word 0x0420_0000. ILLEGAL=1 and all write/read enables are 0. Without the macro, ILLEGAL=0 and both enables are 1.
- Reset mid-stall, plus counter wrap (CNT_W=4): RST_N=0 while OUT_VALID=1 clears all outputs to 0. Then 16 handshakes return DECODE_COUNT to 0.
